// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'd0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of {pc, instr} entries with flush.
// Head output reads as all zeros while the queue is empty.
module fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       din,
  output fetch_entry_t       dout,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;

  // DEPTH is a power of two, so natural pointer overflow gives modulo-DEPTH wrap.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem[wr_ptr] <= din;
  end

  always_comb begin
    dout = '0;
    if (count != '0) dout = mem[rd_ptr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM and feeds the core via a prefetch queue.
// Optional perf counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [15:0]         perf_flush_cnt,
`endif
  output logic                fetch_busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              q_push;
  logic              q_pop;
  fetch_entry_t      q_din;
  fetch_entry_t      q_dout;

  // Handshake: the head transfers on any edge where instr_valid and instr_ready
  // are both high; while instr_valid=1 and instr_ready=0 the head is held unchanged.
  assign pop    = instr_valid & instr_ready;
  assign push   = (count < FULL) | pop;
  assign q_push = push & ~branch_taken;
  assign q_pop  = pop & ~branch_taken;
  assign q_din  = '{pc: fetch_pc, instr: rom_data};

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (branch_taken),
    .din   (q_din),
    .dout  (q_dout),
    .count (count)
  );

  always_ff @(posedge clock) begin
    if (reset)             fetch_pc <= RESET_PC;
    else if (branch_taken) fetch_pc <= branch_target;
    else if (push)         fetch_pc <= fetch_pc + 32'd1;
  end

  assign rom_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_out   = q_dout.instr;
  assign instr_pc    = q_dout.pc;
  assign fetch_busy  = (count == FULL) & ~pop;

`ifdef FETCH_PERF_CNT_EN
  // Only pops that actually retire count; a branch on the same edge discards the pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (q_pop && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (branch_taken && count != '0 && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
